image_streamer: RTL and testbench
=================================

Name: image_streamer

Overview:
- Reads the processed image memory after the effects stage finishes and serialises it into a byte stream for the output file/link.
- Emits bytes in BMP pixel-array order: B, G, R per pixel, with zero padding at the end of each row so every row is a multiple of 4 bytes.
- Uses a valid/ready byte handshake on the output side and a 1-cycle-latency synchronous memory read port on the input side.
- Sits downstream of the output-image memory, which the effects block writes.

Parameters:
- WIDTH, 30, pixels per row.
- HEIGHT, 30, rows per frame.
- ADDR_W, $clog2(WIDTH*HEIGHT), memory address width (10 for 900 pixels).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin streaming one frame; sampled only in IDLE.
- pixel_in  input  24  memory read data: [23:16] red, [15:8] green, [7:0] blue; valid the cycle after the memory samples rd_adrr.
- rd_adrr  output  ADDR_W  registered read address to the image memory.
- byte_out  output  8  stream data.
- byte_valid  output  1  byte_out holds a valid byte.
- byte_ready  input  1  sink accepts the byte; transfer occurs when byte_valid and byte_ready are both high at a rising edge.
- busy  output  1  high from start acceptance until the done pulse.
- done  output  1  one-cycle pulse after the final byte is transferred.

Behaviour:
- Reset values: rd_adrr=0, byte_out=0, byte_valid=0, busy=0, done=0; FSM goes to IDLE; pixel and row counters cleared. This applies mid-frame too; a frame interrupted by reset is abandoned and never resumed.
- PAD = (4 - (3*WIDTH)%4) % 4. WIDTH=30 gives PAD=2.
- Bytes per frame = HEIGHT*(3*WIDTH+PAD). Default frame is 2760 bytes.
- All outputs are registered.
- IDLE:
  - start=1 -> rd_adrr<=0, busy<=1, go to ADDR.
  - start is ignored in every other state.
- ADDR (1 cycle): memory samples rd_adrr. Go to DATA.
- DATA (1 cycle):
  - Latch pixel_in into the pixel register.
  - byte_out<=pixel_in[7:0], byte_valid<=1. Go to SEND.
- SEND, sub-index 0/1/2 = B/G/R:
  - byte_out and byte_valid stay stable while byte_ready=0.
  - On transfer of B or G: load the next component (G=[15:8], R=[23:16]).
  - On transfer of R:
    - If the column counter is WIDTH-1 and PAD>0: go to PAD with byte_out=0, byte_valid=1.
    - Otherwise: end-of-pixel handling.
- PAD: emit PAD bytes of 0x00 under the same handshake, then end-of-pixel handling.
- End-of-pixel handling:
  - Last pixel (address WIDTH*HEIGHT-1): byte_valid<=0, go to FIN.
  - Otherwise: rd_adrr<=rd_adrr+1, byte_valid<=0, go to ADDR. The column counter wraps at WIDTH and the row counter increments.
- FIN (1 cycle): done=1, busy<=0, return to IDLE.
  - start asserted in the FIN cycle is ignored.
  - start asserted in the following IDLE cycle starts a new frame at address 0.
- Throughput with byte_ready held at 1: 5 cycles per pixel (ADDR, DATA, 3 bytes), plus PAD cycles per row, plus 1 FIN cycle.
  - Default frame: start sampled at edge 0; the last byte transfers at edge 4560; done is high in the following cycle.
- Pixels are emitted in memory address order 0..WIDTH*HEIGHT-1. No row reordering is done in this block.
- rd_adrr never exceeds WIDTH*HEIGHT-1.

Test Plan:
- Reset: hold rst=1 for 3 cycles with start=1 -> rd_adrr=0, byte_valid=0, busy=0, done=0 throughout.
- Full frame, byte_ready=1, mem[i]={8'(i+2),8'(i+1),8'(i)}, start pulsed:
  - First bytes are 0x00,0x01,0x02, then 0x01,0x02,0x03.
  - After the 30th pixel (bytes 0x1D,0x1E,0x1F) come two 0x00 pad bytes.
  - Exactly 2760 bytes, one done pulse, 4560 cycles from start to the last transfer.
- Backpressure: drop byte_ready for 10 cycles on a G byte and on a pad byte -> byte_out/byte_valid hold their values, no byte is lost or duplicated, total is still 2760 bytes with a matching checksum.
- start during busy: pulse start at byte 100 and in the FIN cycle -> both ignored, exactly one frame emitted. A start one cycle after done -> second identical frame.
- Reset mid-frame: assert rst at byte 1000, then start -> stream restarts from pixel 0 byte B (0x00), rd_adrr restarts at 0, no done pulse for the aborted frame.
- WIDTH=4, HEIGHT=2 -> PAD=0, 24 bytes with no padding, done after the 24th transfer.

Source files
------------

// File: rtl/image_streamer.sv
// Serialises the processed image memory into a BMP pixel-array byte stream (B,G,R + row padding).
// Latency: 2 cycles from start/next pixel to first byte; a stalled byte holds until byte_ready.
module image_streamer #(
  parameter int WIDTH  = 30,
  parameter int HEIGHT = 30,
  parameter int ADDR_W = $clog2(WIDTH*HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [23:0]       pixel_in,
  output logic [ADDR_W-1:0] rd_adrr,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done
);

  localparam int PAD = (4 - (3*WIDTH) % 4) % 4;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int RW  = $clog2(HEIGHT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(WIDTH*HEIGHT - 1);
  localparam logic [CW-1:0]     LAST_COL = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_SEND, S_PAD, S_FIN
  } state_t;

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] adr_n;
  logic [7:0]        byte_n;
  logic              valid_n, busy_n, done_n;
  logic [15:0]       pix_q, pix_n;   // red/green of the current pixel; blue goes out directly
  logic [1:0]        sub_q, sub_n;
  logic [CW-1:0]     col_q, col_n;
  logic [RW-1:0]     row_q, row_n;
  logic              xfer, eop;

  assign xfer = byte_valid & byte_ready;

  always_comb begin
    state_n = state_q;
    adr_n   = rd_adrr;
    byte_n  = byte_out;
    valid_n = byte_valid;
    busy_n  = busy;
    done_n  = 1'b0;
    pix_n   = pix_q;
    sub_n   = sub_q;
    col_n   = col_q;
    row_n   = row_q;
    eop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          adr_n   = '0;
          busy_n  = 1'b1;
          col_n   = '0;
          row_n   = '0;
          state_n = S_ADDR;
        end
      end
      S_ADDR: state_n = S_DATA;
      S_DATA: begin
        pix_n   = pixel_in[23:8];
        byte_n  = pixel_in[7:0];
        valid_n = 1'b1;
        sub_n   = 2'd0;
        state_n = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          case (sub_q)
            2'd0: begin
              byte_n = pix_q[7:0];
              sub_n  = 2'd1;
            end
            2'd1: begin
              byte_n = pix_q[15:8];
              sub_n  = 2'd2;
            end
            default: begin
              if (col_q == LAST_COL && PAD > 0) begin
                byte_n  = 8'h00;
                valid_n = 1'b1;
                sub_n   = 2'd0;
                state_n = S_PAD;
              end else begin
                eop = 1'b1;
              end
            end
          endcase
        end
      end
      S_PAD: begin
        if (xfer) begin
          if (sub_q == 2'(PAD - 1)) eop = 1'b1;
          else                      sub_n = sub_q + 2'd1;
        end
      end
      S_FIN: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (eop) begin
      valid_n = 1'b0;
      if (rd_adrr == LAST_ADR) begin
        done_n  = 1'b1;
        state_n = S_FIN;
      end else begin
        adr_n   = rd_adrr + ADDR_W'(1);
        state_n = S_ADDR;
        if (col_q == LAST_COL) begin
          col_n = '0;
          row_n = row_q + RW'(1);
        end else begin
          col_n = col_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_adrr    <= '0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pix_q      <= '0;
      sub_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_n;
      rd_adrr    <= adr_n;
      byte_out   <= byte_n;
      byte_valid <= valid_n;
      busy       <= busy_n;
      done       <= done_n;
      pix_q      <= pix_n;
      sub_q      <= sub_n;
      col_q      <= col_n;
      row_q      <= row_n;
    end
  end

endmodule

// File: tb/tb_image_streamer.sv
// Randomised bench for image_streamer: default 30x30 frame plus a 4x2 instance,
// checked against a byte-queue model built from the memory contents.
module tb_image_streamer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // default 30x30 instance
  logic        start_a, vld_a, rdy_a, busy_a, done_a;
  logic [23:0] pix_a;
  logic [9:0]  adr_a;
  logic [7:0]  byte_a;
  logic [23:0] mem_a [0:899];

  image_streamer #(.WIDTH(30), .HEIGHT(30), .ADDR_W(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pixel_in(pix_a), .rd_adrr(adr_a),
    .byte_out(byte_a), .byte_valid(vld_a), .byte_ready(rdy_a), .busy(busy_a), .done(done_a)
  );
  always @(posedge clk) pix_a <= mem_a[adr_a];

  // 4x2 instance (no row padding)
  logic        start_b, vld_b, busy_b, done_b;
  logic        rdy_b = 1'b1;
  logic [23:0] pix_b;
  logic [2:0]  adr_b;
  logic [7:0]  byte_b;
  logic [23:0] mem_b [0:7];

  image_streamer #(.WIDTH(4), .HEIGHT(2), .ADDR_W(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pixel_in(pix_b), .rd_adrr(adr_b),
    .byte_out(byte_b), .byte_valid(vld_b), .byte_ready(rdy_b), .busy(busy_b), .done(done_b)
  );
  always @(posedge clk) pix_b <= mem_b[adr_b];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitors sample on the falling edge; a valid&ready seen here transfers at the next rising edge
  logic [7:0] cap_a[$], exp_a[$], cap_b[$], exp_b[$];
  int done_cnt_a = 0, done_cnt_b = 0;
  int start_edge_a = 0, last_edge_a = 0;
  int start_edge_b = 0, last_edge_b = 0, done_cyc_b = 0;
  int max_adr = 0;
  bit prev_stall = 0;
  logic [7:0] prev_byte = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("hold_vld", vld_a, 1);
        check("hold_dat", byte_a, prev_byte);
      end
      prev_stall = vld_a && !rdy_a;
      prev_byte  = byte_a;
      if (vld_a && rdy_a) begin
        cap_a.push_back(byte_a);
        last_edge_a = cyc + 1;
      end
      if (done_a) done_cnt_a++;
      if (start_a && !busy_a) start_edge_a = cyc + 1;
      if (int'(adr_a) > max_adr) max_adr = int'(adr_a);

      if (vld_b && rdy_b) begin
        cap_b.push_back(byte_b);
        last_edge_b = cyc + 1;
      end
      if (done_b) begin
        done_cnt_b++;
        done_cyc_b = cyc;
      end
      if (start_b && !busy_b) start_edge_b = cyc + 1;
    end else begin
      prev_stall = 0;
    end
  end

  // byte_ready driver: random or always-on, plus two forced 10-cycle stalls (a G byte and a pad byte)
  bit rnd_ready = 0, bp_en = 0, hit_g = 0, hit_pad = 0;
  int stall_left = 0;
  initial begin
    rdy_a = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0) begin
        rdy_a = 1'b0;
        stall_left--;
      end else if (bp_en && vld_a && cap_a.size() == 301 && !hit_g) begin
        hit_g = 1; rdy_a = 1'b0; stall_left = 9;
      end else if (bp_en && vld_a && cap_a.size() == 90 && !hit_pad) begin
        hit_pad = 1; rdy_a = 1'b0; stall_left = 9;
      end else begin
        rdy_a = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // reference: pixels in address order, B G R, each row zero-filled to a multiple of 4 bytes
  task automatic build_exp_a(input int frames);
    exp_a.delete();
    repeat (frames) begin
      for (int r = 0; r < 30; r++) begin
        int len = 0;
        for (int c = 0; c < 30; c++) begin
          logic [23:0] p;
          p = mem_a[r*30 + c];
          exp_a.push_back(p[7:0]); exp_a.push_back(p[15:8]); exp_a.push_back(p[23:16]);
          len += 3;
        end
        while (len % 4 != 0) begin
          exp_a.push_back(8'h00);
          len++;
        end
      end
    end
  endtask

  task automatic compare_a(input string tag);
    int sum_c = 0, sum_e = 0, bad = 0;
    check({tag, "_len"}, cap_a.size(), exp_a.size());
    foreach (cap_a[i]) sum_c += int'(cap_a[i]);
    foreach (exp_a[i]) sum_e += int'(exp_a[i]);
    check({tag, "_sum"}, sum_c, sum_e);
    for (int i = 0; i < cap_a.size() && i < exp_a.size() && bad < 8; i++) begin
      if (cap_a[i] !== exp_a[i]) bad++;
      check({tag, "_byte"}, cap_a[i], exp_a[i]);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 900; i++) mem_a[i] = {8'(i + 2), 8'(i + 1), 8'(i)};
  endtask

  task automatic clear_a();
    cap_a.delete();
    done_cnt_a = 0;
  endtask

  task automatic pulse_start();
    start_a = 1'b1; tick(); start_a = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt_a < target && k < budget) begin tick(); k++; end
    check("done_timeout", done_cnt_a >= target, 1);
  endtask

  task automatic wait_fin();
    int k = 0;
    while (!done_a && k < 6000) begin tick(); k++; end
    check("fin_seen", done_a, 1);
  endtask

  initial begin
    int k;
    rst = 1'b1; start_a = 1'b1; start_b = 1'b0;

    // reset held with start high
    repeat (3) begin
      @(negedge clk);
      check("rst_adr", adr_a, 0);
      check("rst_vld", vld_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
    end
    check("rst_busy_b", busy_b, 0);
    @(posedge clk); #1;
    rst = 1'b0; start_a = 1'b0;
    repeat (3) tick();

    // full frame, ready always high
    fill_pattern(); clear_a(); build_exp_a(1); max_adr = 0;
    pulse_start();
    @(negedge clk);
    check("busy_after_start", busy_a, 1);
    tick();
    wait_done(1, 6000);
    repeat (5) tick();
    compare_a("frame1");
    check("frame1_done_cnt", done_cnt_a, 1);
    check("frame1_latency", last_edge_a - start_edge_a, 4560);
    check("frame1_busy_end", busy_a, 0);
    check("adr_max", max_adr, 899);
    if (cap_a.size() >= 92) begin
      check("b0", cap_a[0], 8'h00); check("b1", cap_a[1], 8'h01); check("b2", cap_a[2], 8'h02);
      check("b3", cap_a[3], 8'h01); check("b4", cap_a[4], 8'h02); check("b5", cap_a[5], 8'h03);
      check("p29_b", cap_a[87], 8'h1D); check("p29_g", cap_a[88], 8'h1E);
      check("p29_r", cap_a[89], 8'h1F);
      check("pad0", cap_a[90], 8'h00); check("pad1", cap_a[91], 8'h00);
    end

    // random contents under random backpressure plus forced stalls
    for (int i = 0; i < 900; i++) mem_a[i] = 24'($urandom);
    clear_a(); build_exp_a(1);
    rnd_ready = 1; bp_en = 1; hit_g = 0; hit_pad = 0;
    pulse_start();
    wait_done(1, 20000);
    repeat (5) tick();
    rnd_ready = 0; bp_en = 0;
    compare_a("bp");
    check("bp_done_cnt", done_cnt_a, 1);
    check("bp_stalls", {30'd0, hit_g, hit_pad}, 3);

    // start while busy and during the done cycle is ignored
    fill_pattern(); clear_a(); build_exp_a(1);
    pulse_start();
    k = 0;
    while (cap_a.size() < 100 && k < 2000) begin tick(); k++; end
    check("reach_byte100", cap_a.size() >= 100, 1);
    pulse_start();
    wait_fin();
    pulse_start();
    repeat (20) tick();
    compare_a("ignore");
    check("ignore_done_cnt", done_cnt_a, 1);
    check("ignore_busy", busy_a, 0);

    // start in the IDLE cycle right after done gives a second identical frame
    clear_a(); build_exp_a(2);
    pulse_start();
    wait_fin();
    tick();
    pulse_start();
    wait_done(2, 6000);
    repeat (5) tick();
    compare_a("b2b");
    check("b2b_done_cnt", done_cnt_a, 2);

    // reset mid-frame abandons the frame
    clear_a(); build_exp_a(1);
    pulse_start();
    k = 0;
    while (cap_a.size() < 1000 && k < 3000) begin tick(); k++; end
    check("reach_byte1000", cap_a.size() >= 1000, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    clear_a();
    @(negedge clk);
    check("mrst_adr", adr_a, 0);
    check("mrst_vld", vld_a, 0);
    check("mrst_busy", busy_a, 0);
    check("mrst_done", done_a, 0);
    tick();
    repeat (10) tick();
    check("mrst_no_done", done_cnt_a, 0);
    pulse_start();
    @(negedge clk);
    check("mrst_restart_adr", adr_a, 0);
    tick();
    wait_done(1, 6000);
    repeat (5) tick();
    compare_a("mrst");
    check("mrst_first", cap_a.size() > 0 ? cap_a[0] : 8'hFF, 8'h00);
    check("mrst_done_cnt", done_cnt_a, 1);

    // 4x2 frame: 12 bytes per row, no padding
    exp_b.delete();
    for (int i = 0; i < 8; i++) begin
      mem_b[i] = 24'($urandom);
      exp_b.push_back(mem_b[i][7:0]); exp_b.push_back(mem_b[i][15:8]); exp_b.push_back(mem_b[i][23:16]);
    end
    start_b = 1'b1; tick(); start_b = 1'b0;
    k = 0;
    while (done_cnt_b < 1 && k < 200) begin tick(); k++; end
    repeat (5) tick();
    check("small_done_cnt", done_cnt_b, 1);
    check("small_len", cap_b.size(), 24);
    for (int i = 0; i < cap_b.size() && i < 24; i++) check("small_byte", cap_b[i], exp_b[i]);
    check("small_latency", last_edge_b - start_edge_b, 40);
    check("small_done_pos", done_cyc_b, last_edge_b);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
